// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared constants and helpers for the memory-mapped GPIO port.
//   - Bus widths, default register addresses, pin count and debounce window.
//   - gpio_reg_e : which GPIO register (if any) an access targets.
//   - gpio_decode: maps a bus address onto gpio_reg_e.
// -----------------------------------------------------------------------------
package gpio_pkg;

  localparam int GPIO_ADDR_W       = 32;
  localparam int GPIO_DATA_W       = 64;

  localparam int GPIO_EDGE_ADDRESS = 253;
  localparam int GPIO_DIR_ADDRESS  = 254;
  localparam int GPIO_RW_ADDRESS   = 255;

  localparam int GPIO_N_PINS       = 13;
  localparam int GPIO_DB_CYCLES    = 16;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_DIR  = 2'd1,
    REG_DATA = 2'd2,
    REG_EDGE = 2'd3
  } gpio_reg_e;

  // Address match against the three register addresses; anything else is
  // not ours and must be ignored.
  function automatic gpio_reg_e gpio_decode(
    input logic [GPIO_ADDR_W-1:0] addr,
    input logic [GPIO_ADDR_W-1:0] dir_a,
    input logic [GPIO_ADDR_W-1:0] data_a,
    input logic [GPIO_ADDR_W-1:0] edge_a
  );
    gpio_reg_e r;
    if (addr == dir_a) begin
      r = REG_DIR;
    end else if (addr == data_a) begin
      r = REG_DATA;
    end else if (addr == edge_a) begin
      r = REG_EDGE;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// gpio_port_ctrl_if
// CPU-side register bus of the GPIO port.
//   address  : CPU memory address
//   sel      : peripheral chip-select (already qualified by data-space select)
//   wr_en    : write strobe
//   rd_en    : read strobe
//   wr_data  : write data
//   rd_data  : read data, zero when not driving
//   rd_valid : high while rd_data carries a register value (bus tri-state enable)
// Modports: master (CPU side), slave (GPIO port side).
// -----------------------------------------------------------------------------
interface gpio_port_ctrl_if;
  import gpio_pkg::*;

  logic [GPIO_ADDR_W-1:0] address;
  logic                   sel;
  logic                   wr_en;
  logic                   rd_en;
  logic [GPIO_DATA_W-1:0] wr_data;
  logic [GPIO_DATA_W-1:0] rd_data;
  logic                   rd_valid;

  modport master (
    output address, sel, wr_en, rd_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  address, sel, wr_en, rd_en, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/gpio_pin_filter.sv
// -----------------------------------------------------------------------------
// gpio_pin_filter
// Input conditioning for one pad: two-flop synchroniser, optional debounce
// filter, and a one-cycle pulse whenever the filtered level changes.
// Build option: GPIO_DEBOUNCE_EN (defined -> debounce present; undefined ->
// pin_db follows the synchroniser output directly, DB_CYCLES unused).
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-low reset
//   pad        : raw pad level
//   pin_db     : filtered pin level
//   edge_pulse : registered, high for the cycle after pin_db changed
// -----------------------------------------------------------------------------
module gpio_pin_filter
  import gpio_pkg::*;
#(
  parameter int DB_CYCLES = GPIO_DB_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic pin_db,
  output logic edge_pulse
);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("gpio_pin_filter: DB_CYCLES must be at least 2");
  end

  logic sync1_r;
  logic sync2_r;

  // Two-flop synchroniser for the asynchronous pad level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pad;
      sync2_r <= sync1_r;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic          db_r;
  logic          edge_r;

  // Debounce: count consecutive cycles where the synchronised level differs
  // from the accepted level; accept it on the DB_CYCLES-th such cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CW{1'b0}};
      db_r   <= 1'b0;
      edge_r <= 1'b0;
    end else if (sync2_r != db_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= {CW{1'b0}};
        db_r   <= sync2_r;
        edge_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CW'(1);
        edge_r <= 1'b0;
      end
    end else begin
      cnt_r  <= {CW{1'b0}};
      edge_r <= 1'b0;
    end
  end

  assign pin_db     = db_r;
  assign edge_pulse = edge_r;
`else
  logic edge_r;

  // Without debounce the synchroniser output is the pin level; a change is
  // seen one stage early as a difference between the two sync flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      edge_r <= 1'b0;
    end else begin
      edge_r <= sync1_r ^ sync2_r;
    end
  end

  assign pin_db     = sync2_r;
  assign edge_pulse = edge_r;
`endif

endmodule

// File: rtl/gpio_port_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_port_ctrl
// Memory-mapped GPIO port: direction, output and sticky edge-capture
// registers behind three bus addresses, plus per-pin input conditioning.
// Build option: GPIO_DEBOUNCE_EN enables the per-pin debounce filter.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : register bus (gpio_port_ctrl_if.slave)
//   io     : N_PINS bidirectional pads, driven only where dir=1
//   irq    : OR of all edge-capture bits
// Register map:
//   DIR_ADDR  : dir, 1 = output
//   DATA_ADDR : write out_reg; read dir ? out_reg : pin_db
//   EDGE_ADDR : edge_reg, write-1-to-clear, a new edge beats a clear
// -----------------------------------------------------------------------------
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int N_PINS    = GPIO_N_PINS,
  parameter int DIR_ADDR  = GPIO_DIR_ADDRESS,
  parameter int DATA_ADDR = GPIO_RW_ADDRESS,
  parameter int EDGE_ADDR = GPIO_EDGE_ADDRESS,
  parameter int DB_CYCLES = GPIO_DB_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  gpio_port_ctrl_if.slave     bus,
  inout  wire  [N_PINS-1:0]   io,
  output logic                irq
);

  if (N_PINS < 1 || N_PINS > 64) begin : g_bad_n_pins
    $error("gpio_port_ctrl: N_PINS must be in 1..64");
  end

  logic [N_PINS-1:0] dir_r;
  logic [N_PINS-1:0] out_r;
  logic [N_PINS-1:0] edge_r;

  logic [N_PINS-1:0] pin_db_s;
  logic [N_PINS-1:0] edge_set_s;
  logic [N_PINS-1:0] edge_clr_s;
  logic [N_PINS-1:0] data_view_s;

  gpio_reg_e         reg_sel_s;
  logic              wr_dir_s;
  logic              wr_data_s;
  logic              wr_edge_s;

  logic [GPIO_DATA_W-1:0] rd_word_s;
  logic                   rd_valid_s;

  // Upper write-data bits have no register behind them.
  wire unused_wr_data_s = &{1'b0, bus.wr_data};

  // Pads and per-pin input conditioning; output pins also feed their own
  // filter so they capture edges like inputs.
  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    assign io[i] = dir_r[i] ? out_r[i] : 1'bz;

    gpio_pin_filter #(
      .DB_CYCLES (DB_CYCLES)
    ) u_filter (
      .clock      (clock),
      .reset      (reset),
      .pad        (io[i]),
      .pin_db     (pin_db_s[i]),
      .edge_pulse (edge_set_s[i])
    );
  end

  // Address decode and write strobes; no chip-select means no target.
  always_comb begin
    reg_sel_s = REG_NONE;
    if (bus.sel) begin
      reg_sel_s = gpio_decode(bus.address, 32'(DIR_ADDR), 32'(DATA_ADDR), 32'(EDGE_ADDR));
    end else begin
      reg_sel_s = REG_NONE;
    end
    wr_dir_s   = bus.wr_en && (reg_sel_s == REG_DIR);
    wr_data_s  = bus.wr_en && (reg_sel_s == REG_DATA);
    wr_edge_s  = bus.wr_en && (reg_sel_s == REG_EDGE);
    edge_clr_s = wr_edge_s ? bus.wr_data[N_PINS-1:0] : {N_PINS{1'b0}};
  end

  // Register file: dir, out_reg and sticky edge capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_r  <= {N_PINS{1'b0}};
      out_r  <= {N_PINS{1'b0}};
      edge_r <= {N_PINS{1'b0}};
    end else begin
      if (wr_dir_s) begin
        dir_r <= bus.wr_data[N_PINS-1:0];
      end
      if (wr_data_s) begin
        out_r <= bus.wr_data[N_PINS-1:0];
      end
      // Clear first, then set, so an edge arriving with the clear survives.
      edge_r <= (edge_r & ~edge_clr_s) | edge_set_s;
    end
  end

  assign data_view_s = (dir_r & out_r) | (~dir_r & pin_db_s);

  // Combinational read mux; a write in the same cycle is not yet visible,
  // so a combined access returns the pre-write value.
  always_comb begin
    rd_word_s  = {GPIO_DATA_W{1'b0}};
    rd_valid_s = 1'b0;
    if (bus.rd_en) begin
      case (reg_sel_s)
        REG_DIR: begin
          rd_word_s[N_PINS-1:0] = dir_r;
          rd_valid_s            = 1'b1;
        end
        REG_DATA: begin
          rd_word_s[N_PINS-1:0] = data_view_s;
          rd_valid_s            = 1'b1;
        end
        REG_EDGE: begin
          rd_word_s[N_PINS-1:0] = edge_r;
          rd_valid_s            = 1'b1;
        end
        default: begin
          rd_word_s  = {GPIO_DATA_W{1'b0}};
          rd_valid_s = 1'b0;
        end
      endcase
    end else begin
      rd_valid_s = 1'b0;
    end
  end

  assign bus.rd_data  = rd_word_s;
  assign bus.rd_valid = rd_valid_s;
  assign irq          = |edge_r;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_port_ctrl
// Directed scoreboard bench for gpio_port_ctrl. Reads push their expected
// value into exp_q; a monitor pops one entry each cycle rd_valid is high.
// Non-bus observations (irq, pads, rd_valid) go through chk_q to the same
// monitor so all comparisons are counted in one place.
// -----------------------------------------------------------------------------
module tb_gpio_port_ctrl;

  localparam int NP = 13;
  localparam logic [31:0] A_EDGE = 32'd253;
  localparam logic [31:0] A_DIR  = 32'd254;
  localparam logic [31:0] A_DATA = 32'd255;

`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 19;  // pad change -> edge_reg: 2 sync + 16 debounce + 1
`else
  localparam int LAT = 3;   // pad change -> edge_reg: 2 sync + 1
`endif

  logic clock;
  logic reset;
  logic irq;
  wire  [NP-1:0] io;
  logic [NP-1:0] tb_en;
  logic [NP-1:0] tb_val;

  gpio_port_ctrl_if bus_if ();

  gpio_port_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if),
    .io    (io),
    .irq   (irq)
  );

  for (genvar g = 0; g < NP; g++) begin : g_drv
    assign io[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } rd_exp_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  rd_exp_t exp_q[$];
  chk_t    chk_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  // Monitor: the only place comparisons are made and counted.
  initial begin : monitor
    rd_exp_t e;
    chk_t    c;
    forever begin
      @(negedge clock);
      if (bus_if.rd_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: rd_data=0x%0h with rd_valid=1, no read expected", bus_if.rd_data);
        end else begin
          e = exp_q.pop_front();
          if (bus_if.rd_data !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, bus_if.rd_data, e.exp);
          end
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_tests++;
        if (c.act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, c.act, c.exp);
        end
      end
    end
  end

  task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic bus_idle();
    bus_if.sel     = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.address = 32'd0;
    bus_if.wr_data = 64'd0;
  endtask

  // One bus cycle; the access is sampled at the second posedge.
  task automatic access(input logic s, input logic [31:0] a, input logic w,
                        input logic r, input logic [63:0] d);
    @(posedge clock);
    #1;
    bus_if.sel     = s;
    bus_if.address = a;
    bus_if.wr_en   = w;
    bus_if.rd_en   = r;
    bus_if.wr_data = d;
    @(posedge clock);
    #1;
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    access(1'b1, a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [63:0] exp);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    access(1'b1, a, 1'b0, 1'b1, 64'd0);
  endtask

  task automatic wrrd(input string name, input logic [31:0] a, input logic [63:0] d,
                      input logic [63:0] exp);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    access(1'b1, a, 1'b1, 1'b1, d);
  endtask

  // Access that must not be decoded: rd_valid has to stay low.
  task automatic rd_ignored(input string name, input logic s, input logic [31:0] a);
    @(posedge clock);
    #1;
    bus_if.sel     = s;
    bus_if.address = a;
    bus_if.rd_en   = 1'b1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = 64'h0000_0000_0000_1FFF;
    #1;
    post(name, {63'd0, bus_if.rd_valid}, 64'd0);
    @(posedge clock);
    #1;
    bus_idle();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus_idle();
    tb_en  = {NP{1'b1}};
    tb_val = {NP{1'b0}};
    reset  = 1'b0;

    // Reset state
    cycles(3);
    post("reset_irq", {63'd0, irq}, 64'd0);
    post("reset_rd_valid", {63'd0, bus_if.rd_valid}, 64'd0);
    post("reset_rd_data", bus_if.rd_data, 64'd0);
    reset = 1'b1;
    cycles(LAT + 2);
    rd("reset_dir", A_DIR, 64'h0);
    rd("reset_data", A_DATA, 64'h0);
    rd("reset_edge", A_EDGE, 64'h0);
    post("reset_irq_after", {63'd0, irq}, 64'd0);

    // Pins 0..1 become outputs
    tb_en = 13'h1FFC;
    wr(A_DIR, 64'h3);
    post("pads_after_dir", {51'd0, io}, 64'h0);
    wr(A_DATA, 64'h1FFF);
    post("pads_after_data", {51'd0, io}, 64'h3);
    rd("dir_readback", A_DIR, 64'h3);
    rd("data_readback", A_DATA, 64'h3);
    cycles(LAT + 2);
    wr(A_EDGE, 64'h1FFF);
    rd("edge_cleared", A_EDGE, 64'h0);
    post("irq_cleared", {63'd0, irq}, 64'd0);

    // Ignored accesses: wrong address, chip-select low
    rd_ignored("ign_addr256_rd_valid", 1'b1, 32'd256);
    rd_ignored("ign_nosel_rd_valid", 1'b0, A_DATA);
    rd_ignored("ign_nosel_dir_rd_valid", 1'b0, A_DIR);
    rd("ign_dir_kept", A_DIR, 64'h3);
    rd("ign_data_kept", A_DATA, 64'h3);
    rd("ign_edge_kept", A_EDGE, 64'h0);

    // Read and write together: read sees pre-write value
    wrrd("rw_data_prewrite", A_DATA, 64'h1FFE, 64'h3);
    rd("rw_data_postwrite", A_DATA, 64'h2);
    wr(A_DATA, 64'h1FFF);
    cycles(LAT + 2);
    wrrd("rw_edge_prewrite", A_EDGE, 64'h1FFF, 64'h1);
    rd("rw_edge_postclear", A_EDGE, 64'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Glitch shorter than the debounce window is filtered out
    tb_val[5] = 1'b1;
    cycles(10);
    tb_val[5] = 1'b0;
    cycles(30);
    rd("glitch_edge", A_EDGE, 64'h0);
    rd("glitch_data", A_DATA, 64'h3);
`endif

    // Rising edge on pin 5 with exact latency
    tb_val[5] = 1'b1;
    cycles(LAT - 1);
    post("p5_irq_early", {63'd0, irq}, 64'd0);
    cycles(1);
    post("p5_irq_set", {63'd0, irq}, 64'd1);
    rd("p5_edge", A_EDGE, 64'h20);
    rd("p5_data", A_DATA, 64'h23);

    // W1C
    wr(A_EDGE, 64'h20);
    rd("w1c_edge", A_EDGE, 64'h0);
    post("w1c_irq", {63'd0, irq}, 64'd0);

    // New edge on pin 5 in the same cycle as its clear: set wins
    tb_val[5] = 1'b0;
    cycles(LAT - 2);
    wr(A_EDGE, 64'h20);
    rd("collide_edge", A_EDGE, 64'h20);
    rd("collide_data", A_DATA, 64'h3);
    wr(A_EDGE, 64'h20);

    // Reset while pin 7 is mid-debounce
    wr(A_DIR, 64'h0);
    tb_en     = {NP{1'b1}};
    tb_val    = {NP{1'b0}};
    cycles(LAT + 2);
    tb_val[7] = 1'b1;
    cycles(10);
    reset = 1'b0;
    #1;
    post("rst_mid_irq", {63'd0, irq}, 64'd0);
    rd("rst_mid_edge", A_EDGE, 64'h0);
    rd("rst_mid_data", A_DATA, 64'h0);
    reset = 1'b1;
    cycles(LAT - 1);
    post("rst_p7_irq_early", {63'd0, irq}, 64'd0);
    cycles(1);
    post("rst_p7_irq_set", {63'd0, irq}, 64'd1);
    rd("rst_p7_edge", A_EDGE, 64'h80);
    rd("rst_p7_data", A_DATA, 64'h80);

    // Every expected read must have been observed
    cycles(3);
    post("reads_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
